// File: rtl/tx_serializer_pkg.sv
// Shared definitions for the word buffers: sizes, FSM encoding and byte-lane order.
// The receive-side packing uses the same lane order, so both ends agree on MSB-first.
package tx_serializer_pkg;

    localparam int DEF_NUM_WORDS  = 20;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte offset 0 selects the most significant lane (bits 31:24).
    localparam logic LANE_MSB_FIRST = 1'b1;

    function automatic logic [1:0] byte_lane(input logic [1:0] idx);
        return LANE_MSB_FIRST ? (2'd3 - idx) : idx;
    endfunction

endpackage

// File: rtl/tx_serializer_if.sv
// Byte stream handshake between the serializer and the UART transmitter.
interface tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/tx_byte_mux.sv
// Combinational byte select from the snapshot; no register stage, so tx_data
// follows the registered offsets with no added latency.
module tx_byte_mux
    import tx_serializer_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int CNT_W     = 5
) (
    input  logic [NUM_WORDS*32-1:0] snap,
    input  logic [CNT_W-1:0]        word_off,
    input  logic [1:0]              byte_off,
    output logic [7:0]              data
);

    logic [31:0] word;
    logic [1:0]  lane;

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_off == CNT_W'(k)) begin
                word = snap[32*k +: 32];
            end
        end
    end

    always_comb begin
        lane = byte_lane(byte_off);
        data = 8'h00;
        unique case (lane)
            2'd0: data = word[7:0];
            2'd1: data = word[15:8];
            2'd2: data = word[23:16];
            2'd3: data = word[31:24];
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/tx_serializer.sv
// Snapshots up to NUM_WORDS result words on start and streams them out as bytes,
// word 0 first and MSB-first within a word, over a valid/ready handshake.
module tx_serializer
    import tx_serializer_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        word_count,
    input  logic [NUM_WORDS*32-1:0] data_in,
    tx_serializer_if.master         tx,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        word_offset,
    output logic [1:0]              byte_offset
);

    state_t                  state_q, state_d;
    logic [NUM_WORDS*32-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        word_q, word_d;
    logic [1:0]              byte_q, byte_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [CNT_W-1:0] eff_cnt;
    logic             xfer;
    logic             last;

    always_comb begin
        eff_cnt = (word_count > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS)
                                                   : word_count;
        xfer    = valid_q & tx.tx_ready;
        last    = (byte_q == 2'(BYTES_PER_WORD - 1)) &&
                  (word_q == cnt_q - CNT_W'(1));

        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d = data_in;
                    cnt_d  = eff_cnt;
                    word_d = '0;
                    byte_d = '0;
                    busy_d = 1'b1;
                    if (eff_cnt == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    // Offsets hold on the final byte so they still name it in DONE.
                    if (last) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d = byte_q + 2'd1;
                        if (byte_q == 2'd3) begin
                            word_d = word_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tx_byte_mux #(
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) u_mux (
        .snap     (snap_q),
        .word_off (word_q),
        .byte_off (byte_q),
        .data     (tx.tx_data)
    );

    assign tx.tx_valid  = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_offset  = word_q;
    assign byte_offset  = byte_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: stimulus queues expected bytes and done
// pulses, an independent monitor pops and compares on every handshake.
module tb_tx_serializer;

    localparam int NW = 20;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     word_count = '0;
    logic [NW*32-1:0]  data_in = '0;
    logic              busy;
    logic              done;
    logic [CW-1:0]     word_offset;
    logic [1:0]        byte_offset;

    tx_serializer_if tx ();

    tx_serializer #(
        .NUM_WORDS (NW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word_count  (word_count),
        .data_in     (data_in),
        .tx          (tx.master),
        .busy        (busy),
        .done        (done),
        .word_offset (word_offset),
        .byte_offset (byte_offset)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    int         n_xfer = 0;
    logic [7:0] last_byte = 8'h00;
    int         max_word = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic set_word(input int k, input logic [31:0] w);
        data_in[32*k +: 32] = w;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Returns at the first negedge where tx_valid is expected.
    task automatic start_xfer(input logic [CW-1:0] cnt);
        @(negedge clk);
        start      = 1'b1;
        word_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        #1;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles", limit);
        end
    endtask

    // Monitor: samples after the bench has driven tx_ready for the next edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (tx.tx_valid === 1'b1 && int'(word_offset) > max_word)
                    max_word = int'(word_offset);
                if (tx.tx_valid === 1'b1 && tx.tx_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL byte_unexpected: got %0h expected none",
                                 tx.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx.tx_data !== e) begin
                            errors++;
                            $display("FAIL byte_data: got %0h expected %0h",
                                     tx.tx_data, e);
                        end
                        n_xfer++;
                        last_byte = tx.tx_data;
                    end
                end
                if (done === 1'b1) begin
                    checks++;
                    if (exp_done == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: got 1 expected 0");
                    end else begin
                        exp_done--;
                    end
                end
            end
        end
    end

    initial begin
        int bcnt;
        int base;
        logic d_seen;

        tx.tx_ready = 1'b1;
        #12;
        check("rst_valid", 32'(tx.tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(tx.tx_data), 0);
        check("rst_offs", {word_offset, byte_offset}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single word at full rate
        set_word(0, 32'hDEADBEEF);
        push_word(32'hDEADBEEF);
        exp_done++;
        start_xfer(5'd1);
        #1;
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            #1;
        end
        check("single_busy_cycles", bcnt, 5);
        check("single_drained", exp_q.size(), 0);

        // Reset in the middle of word 1
        set_word(0, 32'hA0A1A2A3);
        set_word(1, 32'hB0B1B2B3);
        push_word(32'hA0A1A2A3);
        push_word(32'hB0B1B2B3);
        exp_done++;
        start_xfer(5'd2);
        repeat (5) @(negedge clk);
        tx.tx_ready = 1'b0;
        #1;
        check("pre_rst_word", 32'(word_offset), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(tx.tx_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_offs", {word_offset, byte_offset}, 0);
        check("midrst_left", exp_q.size(), 3);
        exp_q.delete();
        exp_done = 0;
        d_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (done === 1'b1) d_seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(d_seen), 0);

        // Backpressure while byte 02 is presented
        set_word(0, 32'h01020304);
        push_word(32'h01020304);
        exp_done++;
        start_xfer(5'd1);
        @(negedge clk);
        tx.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_data", 32'(tx.tx_data), 32'h02);
            check("bp_valid", 32'(tx.tx_valid), 1);
            check("bp_byte_off", 32'(byte_offset), 1);
            @(negedge clk);
        end
        tx.tx_ready = 1'b1;
        wait_done(20);
        @(negedge clk);
        @(negedge clk);
        check("bp_drained", exp_q.size(), 0);

        // Full length, count clamped from 31 to 20
        for (int k = 0; k < NW; k++) begin
            if (k == 19) set_word(k, 32'h000000D3);
            else set_word(k, 32'(k * 16 + k));
        end
        for (int k = 0; k < NW; k++) push_word(data_in[32*k +: 32]);
        exp_done++;
        base = n_xfer;
        max_word = 0;
        start_xfer(5'd31);
        wait_done(200);
        @(negedge clk);
        @(negedge clk);
        check("full_bytes", n_xfer - base, 80);
        check("full_last", 32'(last_byte), 32'hD3);
        check("full_max_word", max_word, 19);
        check("full_drained", exp_q.size(), 0);

        // Zero-length transfer
        exp_done++;
        d_seen = 1'b0;
        start_xfer(5'd0);
        #1;
        check("zero_done", 32'(done), 1);
        if (tx.tx_valid === 1'b1) d_seen = 1'b1;
        @(negedge clk);
        #1;
        if (tx.tx_valid === 1'b1) d_seen = 1'b1;
        check("zero_done_pulse", 32'(done), 0);
        check("zero_no_valid", 32'(d_seen), 0);

        // Start while busy plus data change, then back-to-back start
        set_word(0, 32'h11223344);
        push_word(32'h11223344);
        exp_done++;
        start_xfer(5'd1);
        @(negedge clk);
        start      = 1'b1;
        word_count = 5'd3;
        set_word(0, 32'h55667788);
        set_word(1, 32'h99AABBCC);
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        set_word(0, 32'hCAFEF00D);
        push_word(32'hCAFEF00D);
        exp_done++;
        start_xfer(5'd1);
        #1;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_first", 32'(tx.tx_data), 32'hCA);
        wait_done(20);
        repeat (3) @(negedge clk);
        check("final_bytes_left", exp_q.size(), 0);
        check("final_done_left", exp_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Byte-serializing transmit buffer, the outbound counterpart of the receive word buffer. On a start pulse it snapshots up to NUM_WORDS 32-bit result words and emits them as bytes over a valid/ready handshake to the UART transmitter. Bytes go out word 0 first, and MSB-first within each word (bits 31:24 first), which matches the receive-side packing. It sits between the decision-tree result logic and the UART TX.

## Interface
Parameters:
- NUM_WORDS, 20: words in the snapshot; also the maximum transfer length.
- CNT_W, 5: width of word_count and word_offset; must satisfy 2^CNT_W > NUM_WORDS.

Ports:
- clk, input, 1: the single clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to begin a transfer; honoured only in IDLE.
- word_count, input, CNT_W: number of words to send; sampled with start.
- data_in, input, NUM_WORDS*32: flat word bus; word k is data_in[32k+31:32k].
- tx_data, output, 8: current byte.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: UART TX accepts the byte.
- busy, output, 1: high from the cycle after an accepted start until the DONE state is left.
- done, output, 1: one-cycle pulse after the last byte is accepted.
- word_offset, output, CNT_W: index of the word currently being sent.
- byte_offset, output, 2: index of the byte currently being sent; 0 = bits 31:24.

## Operation
- States are IDLE, SEND and DONE.
- IDLE, start=1:
  - Capture all of data_in into the snapshot registers.
  - Latch the effective count as min(word_count, NUM_WORDS).
  - Clear word_offset and byte_offset.
  - If the effective count is 0, go to DONE with no bytes sent; otherwise go to SEND.
- SEND:
  - tx_valid=1.
  - tx_data = snapshot[word_offset] byte selected by byte_offset: 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
  - A transfer occurs when tx_valid & tx_ready.
  - On a transfer: byte_offset increments. When byte_offset wraps 3→0, word_offset increments.
  - When the transfer is the last byte (byte_offset=3 and word_offset=count−1), go to DONE and hold both offsets.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SEND and DONE; it is not queued.
- data_in changes after capture have no effect on the transfer in progress.
- With tx_valid high and tx_ready low, tx_data, word_offset and byte_offset hold stable.
- tx_valid never drops before the handshake completes.
- Reset state, asynchronous, applied at any time including mid-transfer:
  - state=IDLE;
  - tx_valid=0, busy=0, done=0;
  - snapshot cleared to 0, so tx_data=8'h00;
  - word_offset=0, byte_offset=0.
- A transfer interrupted by reset is abandoned; no done pulse is produced.

## Timing
- Start to first byte: start sampled at edge N; tx_valid=1 and busy=1 from N+1.
- Throughput: one byte per cycle while tx_ready stays high. A transfer of W words therefore occupies 4W SEND cycles minimum.
- Last byte to done: last handshake at edge M; done=1 during cycle M+1; busy=0 and IDLE from M+2.
- Back-to-back transfers: a new start is accepted in the first IDLE cycle (M+2).
- Zero-length transfer: start at N; done=1 at N+1 with tx_valid=0 throughout.
- tx_data is a combinational mux from registered snapshot and offsets, so it has no added latency and is glitch-free relative to clk.

## Structure
- Shared include file, also used by the receive buffer:
  - NUM_WORDS=20 and BYTES_PER_WORD=4;
  - the state encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2);
  - the byte-lane ordering constant that defines MSB-first.
- One sub-module, tx_byte_mux: combinational selection of tx_data from the snapshot, word_offset and byte_offset.
- The FSM, counters and snapshot registers live in tx_serializer.

## Test plan
- Reset mid-SEND: assert rst while the transfer is in word 1 → tx_valid, busy and done are 0 and both offsets are 0 immediately (asynchronous). No done pulse follows.
- Single word, tx_ready held 1: word0=32'hDEADBEEF, word_count=1 → tx_data DE, AD, BE, EF on four consecutive cycles. done pulses on the cycle after EF is accepted. busy is high for 5 cycles.
- Backpressure: word0=32'h01020304, tx_ready low for 3 cycles while byte 02 is presented → 02, tx_valid=1 and byte_offset=1 are held for all 3 cycles. Exactly one 02 is transferred.
- Full length with clamping: word_count=31, word k=32'h000000k0+k → exactly 80 bytes are sent, ending with word 19 byte 3 = 8'hD3 (word 19 = 32'h000000D3). word_offset never exceeds 19.
- Zero-length transfer: word_count=0 → done=1 the cycle after start, tx_valid=0 throughout.
- Start while busy, with snapshot stability: a second start and changed data_in during SEND → no effect; the original bytes complete. A start in the first IDLE cycle after done begins a new transfer.
